cpu_run_ctrl: RTL

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

---
 rtl/cpu_run_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - CPU run controller: reset hold, run/step/pause sequencing, enabled-cycle counter
// Outputs decode straight from registers, so none of them responds combinationally to an input.
module cpu_run_ctrl #(
    parameter int CNT_W        = 16,
    parameter int RESET_CYCLES = 2,
    parameter int RUN_CYCLES   = 107
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_mode,
    input  logic             step,
    input  logic             halt,
    input  logic             restart,
    output logic             cpu_reset,
    output logic             cpu_en,
    output logic [CNT_W-1:0] cycle_count,
    output logic             done,
    output logic             wrapped
);

    localparam logic [2:0] S_HOLD  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_PAUSE = 3'd2;
    localparam logic [2:0] S_STEP  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [7:0]       HOLD_LAST = 8'(RESET_CYCLES - 1);
    localparam bit               AUTO_STOP = (RUN_CYCLES > 0);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'((RUN_CYCLES > 0) ? (RUN_CYCLES - 1) : 0);

    logic [2:0]       state_q, state_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrapped_q, wrapped_d;

    logic en;
    logic stop_req;
    logic [2:0] after_enabled;

    assign en = (state_q == S_RUN) || (state_q == S_STEP);

    // halt outranks the automatic stop, but both land in DONE with the coincident cycle counted
    assign stop_req = halt || (AUTO_STOP && en && (cnt_q == LAST_CNT));

    assign after_enabled = step_mode ? S_PAUSE : S_RUN;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cnt_d      = cnt_q;
        wrapped_d  = wrapped_q;

        if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (&cnt_q) begin
                wrapped_d = 1'b1;
            end
        end

        if (restart) begin
            state_d    = S_HOLD;
            hold_cnt_d = '0;
            cnt_d      = '0;
            wrapped_d  = 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        state_d    = after_enabled;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
                S_RUN: begin
                    if (stop_req) begin
                        state_d = S_DONE;
                    end else if (step_mode) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (stop_req) begin
                        state_d = S_DONE;
                    end else if (!step_mode) begin
                        state_d = S_RUN;
                    end else if (step) begin
                        state_d = S_STEP;
                    end
                end
                S_STEP: begin
                    if (stop_req) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = after_enabled;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
            cnt_q      <= '0;
            wrapped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cnt_q      <= cnt_d;
            wrapped_q  <= wrapped_d;
        end
    end

    assign cpu_reset   = (state_q == S_HOLD);
    assign cpu_en      = en;
    assign done        = (state_q == S_DONE);
    assign cycle_count = cnt_q;
    assign wrapped     = wrapped_q;

endmodule
